// File: rtl/sram_responder_pkg.sv
// Shared definitions for the read/write controller and its memory-side
// responder. Both ends import this package so they decode the same
// instruction constants and agree on the responder's state names.
package rw_pkg;

  // 2-bit command encodings carried on the instruction bus.
  localparam logic [1:0] INSTR_IDLE    = 2'b00;
  localparam logic [1:0] INSTR_READ    = 2'b01;
  localparam logic [1:0] INSTR_WRITE   = 2'b10;
  localparam logic [1:0] INSTR_ILLEGAL = 2'b11;

  // Responder states: idle, read in flight, write in flight.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } resp_state_t;

endpackage

// File: rtl/sram_responder_if.sv
// Command/response bundle between the controller (master) and the
// memory-side responder (slave).
//   instruction : command, see rw_pkg encodings
//   addr_r      : read address
//   addr_w      : write address
//   data_w      : write data
//   data_r      : registered read data from the responder
//   busy        : access in flight
//   err         : one-cycle pulse on an illegal command
interface sram_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [1:0]        instruction;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] data_r;
  logic              busy;
  logic              err;

  modport master (
    output instruction, addr_r, addr_w, data_w,
    input  data_r, busy, err
  );

  modport slave (
    input  instruction, addr_r, addr_w, data_w,
    output data_r, busy, err
  );

endinterface

// File: rtl/sram_responder_array.sv
// 2^ADDR_W x DATA_W register array with one write port and one registered
// read port. A synchronous active-low clear zeroes every word and the read
// register. The read register only updates when re is high, so it holds
// the last read value between accesses.
//   clk, n_rst   : clock, synchronous active-low clear
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port
module sram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: decodes the controller's instruction bus, performs
// one read or one write into a 256x8 array per accepted command, and holds
// busy high for LATENCY cycles per access. Illegal commands pulse err.
//   clk   : clock
//   n_rst : synchronous active-low reset
//   bus   : slave side of sram_responder_if (instruction, addresses,
//           write data in; data_r, busy, err out; all outputs registered)
module sram_responder
  import rw_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  sram_responder_if.slave  bus
);

  // Counter starts at LATENCY-1 so the access lands on edge E0+LATENCY.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  resp_state_t       state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_r_lat;
  logic [ADDR_W-1:0] addr_w_lat;
  logic [DATA_W-1:0] data_w_lat;
  logic              busy_flag;
  logic              err_flag;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rdata;

  // The access executes on the edge where the counter has reached zero.
  assign we = (state == WR) && (cnt == 4'd0);
  assign re = (state == RD) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      err_flag <= 1'b0;
      case (state)
        IDLE: begin
          case (bus.instruction)
            INSTR_READ: begin
              addr_r_lat <= bus.addr_r;
              cnt        <= CNT_INIT;
              busy_flag  <= 1'b1;
              state      <= RD;
            end
            INSTR_WRITE: begin
              addr_w_lat <= bus.addr_w;
              data_w_lat <= bus.data_w;
              cnt        <= CNT_INIT;
              busy_flag  <= 1'b1;
              state      <= WR;
            end
            INSTR_ILLEGAL: err_flag <= 1'b1;
            INSTR_IDLE:    ;
            default:       ;
          endcase
        end
        RD, WR: begin
          // Commands arriving while busy are ignored; latched operands stay.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            busy_flag <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (we),
    .waddr (addr_w_lat),
    .wdata (data_w_lat),
    .re    (re),
    .raddr (addr_r_lat),
    .rdata (rdata)
  );

  assign bus.data_r = rdata;
  assign bus.busy   = busy_flag;
  assign bus.err    = err_flag;

endmodule
